bus_noc_rx_bridge: RTL and testbench

- Receive-side bridge between the shared round-robin bus and a router's local port (port 4), carrying traffic in the bus-to-NoC direction.
- Watches the bus for packets whose destination address matches this router and captures them flit by flit into a FIFO.
- Re-injects captured packets into the router local input using the credit handshake.
- Non-matching bus traffic is ignored and receives no credit from this block.

---
 rtl/bus_noc_rx_bridge_if.sv | 25 ++
 rtl/bus_noc_rx_bridge.sv | 126 ++++++++++++
 tb/tb_bus_noc_rx_bridge.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_noc_rx_bridge_if.sv
// Bus-side and router-side signals of the receive bridge, bundled for port hookup.
// slave: bridge view. master: the bus/router environment that drives it.
interface bus_noc_rx_bridge_if #(
    parameter int FLIT_WIDTH = 32
);
    logic                  rx_b;
    logic [FLIT_WIDTH-1:0] data_in_b;
    logic [FLIT_WIDTH-1:0] tx_addr_b;
    logic                  credit_o_b;
    logic                  tx;
    logic [FLIT_WIDTH-1:0] data_out;
    logic                  credit_i;
    logic                  receiving;
    logic [15:0]           pkt_count;

    modport slave (
        input  rx_b, data_in_b, tx_addr_b, credit_i,
        output credit_o_b, tx, data_out, receiving, pkt_count
    );

    modport master (
        output rx_b, data_in_b, tx_addr_b, credit_i,
        input  credit_o_b, tx, data_out, receiving, pkt_count
    );
endinterface

// File: rtl/bus_noc_rx_bridge.sv
// Captures bus packets addressed to this router into a first-word fall-through FIFO
// and replays them into the router local port using the credit handshake.
module bus_noc_rx_bridge #(
    parameter logic [15:0] ROUTER_ADDRESS = 16'h0000,
    parameter int          FLIT_WIDTH     = 32,
    parameter int          FIFO_DEPTH     = 8
) (
    input  logic               clock,
    input  logic               reset,
    bus_noc_rx_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SIZE    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [15:0]           r_remaining;
    logic [15:0]           w_remaining_next;
    logic [15:0]           r_pkt_count;
    logic                  w_pkt_done;
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FLIT_WIDTH-1:0] r_last_head;
    logic [FLIT_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_credit;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_addr_match;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_addr_match = (bus.tx_addr_b[15:0] == ROUTER_ADDRESS);

    // Destination address only gates the header; the rest of a packet follows unconditionally.
    always_comb begin
        w_credit = 1'b0;
        case (r_state)
            S_IDLE:  w_credit = w_addr_match && !w_full;
            default: w_credit = !w_full;
        endcase
    end

    assign bus.credit_o_b = reset && w_credit;
    assign w_push         = bus.rx_b && bus.credit_o_b;
    assign w_pop          = !w_empty && bus.credit_i;

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_pkt_done       = 1'b0;
        if (w_push) begin
            case (r_state)
                S_IDLE: w_state_next = S_SIZE;
                S_SIZE: begin
                    w_remaining_next = bus.data_in_b[15:0];
                    if (bus.data_in_b[15:0] == 16'd0) begin
                        w_state_next = S_IDLE;
                        w_pkt_done   = 1'b1;
                    end else begin
                        w_state_next = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    w_remaining_next = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_state_next = S_IDLE;
                        w_pkt_done   = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_remaining <= 16'd0;
            r_pkt_count <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    // Storage carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.data_in_b;
        end
    end

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last_head <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_last_head <= w_head;
            end
        end
    end

    // When empty, keep showing the flit that was last handed to the router.
    assign bus.tx        = !w_empty;
    assign bus.data_out  = w_empty ? r_last_head : w_head;
    assign bus.receiving = (r_state == S_SIZE) || (r_state == S_PAYLOAD);
    assign bus.pkt_count = r_pkt_count;

endmodule

// File: tb/tb_bus_noc_rx_bridge.sv
// Directed bench for bus_noc_rx_bridge: a per-cycle vector table plus hand-written
// sequences for back-pressure, reset mid-packet and pointer wrap.
module tb_bus_noc_rx_bridge;
    logic clock;
    logic reset;

    bus_noc_rx_bridge_if #(.FLIT_WIDTH(32)) bus ();

    bus_noc_rx_bridge #(
        .ROUTER_ADDRESS(16'h0101),
        .FLIT_WIDTH    (32),
        .FIFO_DEPTH    (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rx;
        logic [31:0] d;
        logic [31:0] a;
        logic        ci;
        logic        e_cred;
        logic        e_tx;
        logic [31:0] e_data;
        logic        e_recv;
        logic [15:0] e_pkt;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    int errors = 0;
    int checks = 0;
    logic [31:0] send_q [$];
    logic [31:0] exp_q  [$];
    bit mon_en  = 1'b0;
    bit occ_chk = 1'b0;
    int occ     = 0;

    function automatic vec_t mk(input logic rx, input logic [31:0] d, input logic [31:0] a,
                                input logic ci, input logic ec, input logic et,
                                input logic [31:0] ed, input logic er, input logic [15:0] ep);
        vec_t v;
        v.rx = rx; v.d = d; v.a = a; v.ci = ci;
        v.e_cred = ec; v.e_tx = et; v.e_data = ed; v.e_recv = er; v.e_pkt = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_cycles(input int budget, output int accepted);
        logic [31:0] tmp;
        accepted = 0;
        for (int c = 0; c < budget && send_q.size() > 0; c++) begin
            bus.rx_b      = 1'b1;
            bus.data_in_b = send_q[0];
            @(negedge clock);
            if (bus.credit_o_b) begin
                tmp = send_q.pop_front();
                accepted++;
            end
            @(posedge clock); #1;
        end
        bus.rx_b = 1'b0;
    endtask

    task automatic send_all(input string name, input int budget);
        int acc;
        send_cycles(budget, acc);
        chk({name, "_send_left"}, send_q.size(), 0);
    endtask

    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            @(posedge clock); #1;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic queue_pkt(input logic [31:0] hdr, input logic [31:0] sz, input logic [31:0] base);
        send_q.push_back(hdr); exp_q.push_back(hdr);
        send_q.push_back(sz);  exp_q.push_back(sz);
        for (int i = 0; i < int'(sz[15:0]); i++) begin
            send_q.push_back(base + i);
            exp_q.push_back(base + i);
        end
    endtask

    // Router-side monitor: predicts each handshake at the negedge before the edge that commits it.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                occ = 0;
            end else begin
                if (bus.tx && bus.credit_i) begin
                    if (mon_en) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rt_flit: unexpected flit %h, expected none", bus.data_out);
                        end else begin
                            chk("rt_flit", bus.data_out, exp_q.pop_front());
                        end
                    end
                    occ--;
                end
                if (bus.rx_b && bus.credit_o_b) occ++;
                if (occ_chk) begin
                    checks++;
                    if (occ > 1) begin
                        errors++;
                        $display("FAIL occupancy: got %0d, expected <= 1", occ);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        bus.rx_b      = 1'b0;
        bus.data_in_b = 32'd0;
        bus.tx_addr_b = 32'h0000_0101;
        bus.credit_i  = 1'b0;
        reset         = 1'b0;

        tbl[0]  = mk(1, 32'h0000_0202, 32'h0000_0202, 1, 0, 0, 32'h0,         0, 16'd0);
        tbl[1]  = mk(1, 32'h0000_0202, 32'h0000_0202, 1, 0, 0, 32'h0,         0, 16'd0);
        tbl[2]  = mk(1, 32'h0000_0202, 32'h0000_0202, 1, 0, 0, 32'h0,         0, 16'd0);
        tbl[3]  = mk(1, 32'h0000_0101, 32'h0000_0101, 1, 1, 0, 32'h0,         0, 16'd0);
        tbl[4]  = mk(1, 32'h0000_0003, 32'h0000_0101, 1, 1, 1, 32'h0000_0101, 1, 16'd0);
        tbl[5]  = mk(1, 32'h0000_00A1, 32'h0000_0101, 1, 1, 1, 32'h0000_0003, 1, 16'd0);
        tbl[6]  = mk(1, 32'h0000_00A2, 32'h0000_0101, 1, 1, 1, 32'h0000_00A1, 1, 16'd0);
        tbl[7]  = mk(1, 32'h0000_00A3, 32'h0000_0101, 1, 1, 1, 32'h0000_00A2, 1, 16'd0);
        tbl[8]  = mk(0, 32'h0,         32'h0000_0101, 1, 1, 1, 32'h0000_00A3, 0, 16'd1);
        tbl[9]  = mk(0, 32'h0,         32'h0000_0202, 1, 0, 0, 32'h0000_00A3, 0, 16'd1);
        tbl[10] = mk(1, 32'h0101_0055, 32'h0000_0101, 1, 1, 0, 32'h0000_00A3, 0, 16'd1);
        tbl[11] = mk(1, 32'hFFFF_0000, 32'h0000_0101, 1, 1, 1, 32'h0101_0055, 1, 16'd1);
        tbl[12] = mk(1, 32'h0000_0101, 32'h0000_0101, 1, 1, 1, 32'hFFFF_0000, 0, 16'd2);
        tbl[13] = mk(1, 32'h0000_0000, 32'h0000_0101, 1, 1, 1, 32'h0000_0101, 1, 16'd2);
        tbl[14] = mk(0, 32'h0,         32'h0000_0202, 1, 0, 1, 32'h0000_0000, 0, 16'd3);
        tbl[15] = mk(0, 32'h0,         32'h0000_0202, 1, 0, 0, 32'h0000_0000, 0, 16'd3);

        // Reset state, with a matching address so credit would otherwise be offered.
        #2;
        chk("rst_credit", bus.credit_o_b, 0);
        chk("rst_tx",     bus.tx, 0);
        chk("rst_recv",   bus.receiving, 0);
        chk("rst_pkt",    bus.pkt_count, 0);
        chk("rst_data",   bus.data_out, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < NV; i++) begin
            bus.rx_b      = tbl[i].rx;
            bus.data_in_b = tbl[i].d;
            bus.tx_addr_b = tbl[i].a;
            bus.credit_i  = tbl[i].ci;
            @(negedge clock);
            chk($sformatf("v%0d_credit", i), bus.credit_o_b, tbl[i].e_cred);
            chk($sformatf("v%0d_tx", i),     bus.tx,         tbl[i].e_tx);
            chk($sformatf("v%0d_data", i),   bus.data_out,   tbl[i].e_data);
            chk($sformatf("v%0d_recv", i),   bus.receiving,  tbl[i].e_recv);
            chk($sformatf("v%0d_pkt", i),    bus.pkt_count,  tbl[i].e_pkt);
            $display("vec %0d rx_b=%0b data_in=%h credit_o_b=%0b tx=%0b data_out=%h recv=%0b pkt=%0d",
                     i, bus.rx_b, bus.data_in_b, bus.credit_o_b, bus.tx, bus.data_out,
                     bus.receiving, bus.pkt_count);
            @(posedge clock); #1;
        end
        bus.rx_b      = 1'b0;
        bus.tx_addr_b = 32'h0000_0101;

        // Back-pressure: 10-flit packet into an 8-deep FIFO with the router stalled.
        mon_en       = 1'b1;
        bus.credit_i = 1'b0;
        queue_pkt(32'h0000_0101, 32'h0000_0008, 32'h0000_00B1);
        send_cycles(14, acc);
        chk("bp_accepted", acc, 8);
        @(negedge clock);
        chk("bp_credit_low", bus.credit_o_b, 0);
        chk("bp_tx_high",    bus.tx, 1);
        chk("bp_head",       bus.data_out, 32'h0000_0101);
        chk("bp_recv",       bus.receiving, 1);
        @(posedge clock); #1;
        bus.credit_i = 1'b1;
        send_all("bp", 20);
        drain("bp", 30);
        @(negedge clock);
        chk("bp_pkt", bus.pkt_count, 4);
        $display("backpressure packet drained, pkt_count=%0d", bus.pkt_count);
        @(posedge clock); #1;

        // Reset after the 3rd flit of a 6-flit packet, router stalled so tx is high.
        mon_en       = 1'b0;
        bus.credit_i = 1'b0;
        send_q.push_back(32'h0000_0101);
        send_q.push_back(32'h0000_0004);
        send_q.push_back(32'h0000_00D1);
        send_all("rmp", 10);
        reset = 1'b0;
        #1;
        chk("rmp_tx",     bus.tx, 0);
        chk("rmp_recv",   bus.receiving, 0);
        chk("rmp_pkt",    bus.pkt_count, 0);
        chk("rmp_credit", bus.credit_o_b, 0);
        chk("rmp_data",   bus.data_out, 0);
        @(posedge clock); #1;
        reset        = 1'b1;
        bus.credit_i = 1'b1;
        mon_en       = 1'b1;
        queue_pkt(32'h0000_0101, 32'h0000_0001, 32'h0000_00C1);
        send_all("post_rst", 10);
        drain("post_rst", 10);
        @(negedge clock);
        chk("post_rst_pkt", bus.pkt_count, 1);
        $display("post-reset packet received, pkt_count=%0d", bus.pkt_count);
        @(posedge clock); #1;

        // 20 back-to-back N=2 packets: pointers wrap many times at occupancy 1.
        reset = 1'b0;
        @(posedge clock); #1;
        reset   = 1'b1;
        occ_chk = 1'b1;
        for (int p = 0; p < 20; p++) begin
            queue_pkt(32'h1000_0000 + p, 32'h0000_0002, 32'h2000_0000 + 32'(p * 2));
        end
        send_all("wrap", 200);
        drain("wrap", 20);
        occ_chk = 1'b0;
        @(negedge clock);
        chk("wrap_pkt", bus.pkt_count, 20);
        $display("wrap stream done, pkt_count=%0d", bus.pkt_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
